// File: rtl/mc_controller.sv
// Multicycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a variable-latency memory handshake.
// Latency: ALU 4, branch/JAL/JALR 3, load 5, store 4 cycles with zero-wait memory; strobes decode combinationally.
// Backpressure: mem_req is held until mem_ready; a bounded wait (MEM_TIMEOUT) ends in a sticky timeout trap.
module mc_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int EN_TIMEOUT  = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_contr,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             comp,
    input  logic             mem_ready,
    output logic             irEn,
    output logic             pcEn,
    output logic [1:0]       pc_select,
    output logic             aluSrc,
    output logic             regWrite,
    output logic [1:0]       memToReg,
    output logic             isByte,
    output logic             isHalf,
    output logic             isWord,
    output logic             memRead,
    output logic             memWrite,
    output logic             mem_req,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_SIZE    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    state_t      state;
    logic [15:0] waitCnt;

    logic isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isOpImm, isOp, isSystem;
    logic isLegal, badSize, finishesInExec;
    logic memStage, timeoutHit, complete;

    // func7 carries no meaning for this revision's control decisions.
    logic unusedFunc7;
    assign unusedFunc7 = ^func7;

    assign isLui    = (opcode == OPC_LUI);
    assign isAuipc  = (opcode == OPC_AUIPC);
    assign isJal    = (opcode == OPC_JAL);
    assign isJalr   = (opcode == OPC_JALR);
    assign isBranch = (opcode == OPC_BRANCH);
    assign isLoad   = (opcode == OPC_LOAD);
    assign isStore  = (opcode == OPC_STORE);
    assign isOpImm  = (opcode == OPC_OPIMM);
    assign isOp     = (opcode == OPC_OP);
    assign isSystem = (opcode == OPC_SYSTEM);

    assign isLegal = isLui | isAuipc | isJal | isJalr | isBranch | isLoad |
                     isStore | isOpImm | isOp | isSystem;

    // Loads reject the RV64/reserved widths; stores only have byte/half/word.
    assign badSize = (isLoad  && (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111)) ||
                     (isStore && (func3[2] || func3 == 3'b011));

    assign finishesInExec = isBranch | isJal | isJalr;

    assign memStage = (state == S_FETCH) || (state == S_MEM);

    // mem_ready in the deadline cycle still wins over the timeout.
    assign timeoutHit = (EN_TIMEOUT != 0) && memStage && !mem_ready &&
                        (waitCnt == 16'(MEM_TIMEOUT));

    assign complete = (state == S_WB) ||
                      (state == S_EXEC && finishesInExec) ||
                      (state == S_MEM && isStore && mem_ready);

    // Datapath strobes decoded from the current state and instruction fields.
    always_comb begin
        irEn      = 1'b0;
        pcEn      = 1'b0;
        pc_select = 2'b00;
        aluSrc    = 1'b0;
        regWrite  = 1'b0;
        memToReg  = 2'b00;
        isByte    = 1'b0;
        isHalf    = 1'b0;
        isWord    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        mem_req   = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                memRead = 1'b1;
                isWord  = 1'b1;
                irEn    = mem_ready;
            end
            S_EXEC: begin
                aluSrc = !(isOp || isBranch);
                if (isBranch) begin
                    pcEn      = 1'b1;
                    pc_select = comp ? 2'b01 : 2'b00;
                end
                if (isJal || isJalr) begin
                    regWrite  = 1'b1;
                    memToReg  = 2'b10;
                    pcEn      = 1'b1;
                    pc_select = isJalr ? 2'b10 : 2'b01;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                aluSrc   = 1'b1;
                memRead  = isLoad;
                memWrite = isStore;
                isByte   = (func3[1:0] == 2'b00);
                isHalf   = (func3[1:0] == 2'b01);
                isWord   = (func3[1:0] == 2'b10);
                // A store retires on the handshake, so the PC advances here.
                if (isStore && mem_ready) begin
                    pcEn = 1'b1;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                pcEn     = 1'b1;
                aluSrc   = !(isOp || isBranch);
                if (isLoad) begin
                    memToReg = 2'b01;
                end else if (isLui) begin
                    memToReg = 2'b11;
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer, memory wait counter, retire counter and sticky halt/trap status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            waitCnt    <= 16'd0;
            retired    <= '0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else if (complete) begin
            retired <= retired + CNT_W'(1);
            waitCnt <= 16'd0;
            state   <= go_contr ? S_FETCH : S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (go_contr) begin
                        waitCnt <= 16'd0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        waitCnt <= 16'd0;
                        // Stores completed above; only fetch and load remain here.
                        state   <= (state == S_FETCH) ? S_DECODE : S_WB;
                    end else if (timeoutHit) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                    end else if (waitCnt != 16'hFFFF) begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    if (!isLegal) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else if (badSize) begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_SIZE;
                    end else if (isSystem) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (isLoad || isStore) begin
                        waitCnt <= 16'd0;
                        state   <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                default: begin
                    // HALT and TRAP are terminal until reset; WB always completes.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed latency/trap/reset scenarios plus randomized instruction streams.
// A stage-list reference model predicts every output each cycle; literal checks pin the model's timing.
// Memory readiness is randomized or scheduled per cycle to exercise the request/ready handshake.
module tb_mc_controller;

    localparam int TMO = 16;

    localparam logic [6:0] O_LUI    = 7'b0110111;
    localparam logic [6:0] O_AUIPC  = 7'b0010111;
    localparam logic [6:0] O_JAL    = 7'b1101111;
    localparam logic [6:0] O_JALR   = 7'b1100111;
    localparam logic [6:0] O_BR     = 7'b1100011;
    localparam logic [6:0] O_LOAD   = 7'b0000011;
    localparam logic [6:0] O_STORE  = 7'b0100011;
    localparam logic [6:0] O_IMM    = 7'b0010011;
    localparam logic [6:0] O_OP     = 7'b0110011;
    localparam logic [6:0] O_SYS    = 7'b1110011;

    localparam int K_ILL = 0, K_SIZE = 1, K_SYS = 2, K_ALU = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_LOAD = 7, K_STORE = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go_contr = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic        comp = 1'b0;
    logic        mem_ready = 1'b0;
    logic        irEn, pcEn, aluSrc, regWrite, isByte, isHalf, isWord;
    logic        memRead, memWrite, mem_req, halted, trap;
    logic [1:0]  pc_select, memToReg, trap_cause;
    logic [31:0] retired;

    mc_controller #(.MEM_TIMEOUT(TMO), .EN_TIMEOUT(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .go_contr(go_contr), .opcode(opcode),
        .func3(func3), .func7(func7), .comp(comp), .mem_ready(mem_ready),
        .irEn(irEn), .pcEn(pcEn), .pc_select(pc_select), .aluSrc(aluSrc),
        .regWrite(regWrite), .memToReg(memToReg), .isByte(isByte),
        .isHalf(isHalf), .isWord(isWord), .memRead(memRead),
        .memWrite(memWrite), .mem_req(mem_req), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;
    bit cmpOn = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: instruction as a list of stages ----------------
    bit          mIdle = 1'b1;
    bit          mStop = 1'b0;
    bit          mHalt = 1'b0;
    bit          mTrap = 1'b0;
    logic [1:0]  mCause = 2'b00;
    logic [31:0] mRet = '0;
    string       mPlan = "FD";
    int          mPos = 0;
    int          mWait = 0;

    function automatic int kindOf(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            O_LUI, O_AUIPC, O_IMM, O_OP: return K_ALU;
            O_BR:    return K_BR;
            O_JAL:   return K_JAL;
            O_JALR:  return K_JALR;
            O_LOAD:  return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_SIZE : K_LOAD;
            O_STORE: return (f3[2] || f3 == 3'd3) ? K_SIZE : K_STORE;
            O_SYS:   return K_SYS;
            default: return K_ILL;
        endcase
    endfunction

    function automatic string planOf(input int k);
        case (k)
            K_ALU:                return "FDEW";
            K_BR, K_JAL, K_JALR:  return "FDE";
            K_LOAD:               return "FDEMW";
            K_STORE:              return "FDEM";
            default:              return "FD";
        endcase
    endfunction

    task automatic modelReset();
        mIdle = 1'b1; mStop = 1'b0; mHalt = 1'b0; mTrap = 1'b0;
        mCause = 2'b00; mRet = '0; mPlan = "FD"; mPos = 0; mWait = 0;
    endtask

    task automatic modelStep();
        byte st;
        int  k;
        if (mStop) return;
        if (mIdle) begin
            if (go_contr) begin
                mIdle = 1'b0; mPlan = "FD"; mPos = 0; mWait = 0;
            end
            return;
        end
        st = mPlan[mPos];
        if ((st == "F" || st == "M") && !mem_ready) begin
            if (mWait == TMO) begin
                mStop = 1'b1; mTrap = 1'b1; mCause = 2'b10;
            end else begin
                mWait++;
            end
            return;
        end
        mWait = 0;
        if (st == "F") begin
            mPos = 1;
        end else if (st == "D") begin
            k = kindOf(opcode, func3);
            if (k == K_ILL) begin
                mStop = 1'b1; mTrap = 1'b1; mCause = 2'b01;
            end else if (k == K_SIZE) begin
                mStop = 1'b1; mTrap = 1'b1; mCause = 2'b11;
            end else if (k == K_SYS) begin
                mStop = 1'b1; mHalt = 1'b1;
            end else begin
                mPlan = planOf(k); mPos = 2;
            end
        end else if (mPos == mPlan.len() - 1) begin
            mRet = mRet + 32'd1;
            if (go_contr) begin
                mPlan = "FD"; mPos = 0;
            end else begin
                mIdle = 1'b1;
            end
        end else begin
            mPos++;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelReset();
            else modelStep();
        end
    end

    task automatic compareAll();
        logic eIr, ePc, eAlu, eRw, eB, eH, eW, eRd, eWr, eReq;
        logic [1:0] eSel, eM2r;
        byte st;
        int  k;
        eIr = 0; ePc = 0; eAlu = 0; eRw = 0; eB = 0; eH = 0; eW = 0;
        eRd = 0; eWr = 0; eReq = 0; eSel = 2'b00; eM2r = 2'b00;
        st = "-";
        if (!mIdle && !mStop) st = mPlan[mPos];
        k = kindOf(opcode, func3);
        if (st == "F") begin
            eReq = 1; eRd = 1; eW = 1; eIr = mem_ready;
        end else if (st == "E") begin
            eAlu = !(opcode == O_OP || k == K_BR);
            if (k == K_BR) begin ePc = 1; eSel = comp ? 2'b01 : 2'b00; end
            if (k == K_JAL || k == K_JALR) begin
                eRw = 1; eM2r = 2'b10; ePc = 1; eSel = (k == K_JALR) ? 2'b10 : 2'b01;
            end
        end else if (st == "M") begin
            eReq = 1; eAlu = 1; eRd = (k == K_LOAD); eWr = (k == K_STORE);
            eB = (func3[1:0] == 2'b00); eH = (func3[1:0] == 2'b01); eW = (func3[1:0] == 2'b10);
            ePc = (k == K_STORE) && mem_ready;
        end else if (st == "W") begin
            eRw = 1; ePc = 1; eAlu = !(opcode == O_OP);
            eM2r = (k == K_LOAD) ? 2'b01 : (opcode == O_LUI) ? 2'b11 : 2'b00;
        end
        check("irEn", irEn, eIr);
        check("pcEn", pcEn, ePc);
        check("pc_select", pc_select, eSel);
        check("aluSrc", aluSrc, eAlu);
        check("regWrite", regWrite, eRw);
        check("memToReg", memToReg, eM2r);
        check("isByte", isByte, eB);
        check("isHalf", isHalf, eH);
        check("isWord", isWord, eW);
        check("memRead", memRead, eRd);
        check("memWrite", memWrite, eWr);
        check("mem_req", mem_req, eReq);
        check("halted", halted, mHalt);
        check("trap", trap, mTrap);
        check("trap_cause", trap_cause, mCause);
        check("retired", retired, mRet);
    endtask

    // Single compare process, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmpOn) compareAll();
        end
    end

    // ---------------- stimulus helpers ----------------
    bit   readySched[$];
    logic irT[40], pcT[40], rwT[40], rdT[40], wT[40], reqT[40], trapT[40], haltT[40];
    logic [1:0] selT[40], m2rT[40];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; go_contr = 1'b0; mem_ready = 1'b0; comp = 1'b0;
        opcode = '0; func3 = '0; readySched.delete();
        tick();
        reset = 1'b0;
    endtask

    // Runs n cycles (cycle 1 is the current one) and records the strobes of each.
    task automatic trace(input int n);
        for (int c = 1; c <= n; c++) begin
            if (readySched.size() > 0) mem_ready = readySched.pop_front();
            else mem_ready = 1'b1;
            #3;
            irT[c] = irEn; pcT[c] = pcEn; rwT[c] = regWrite; rdT[c] = memRead;
            wT[c] = isWord; reqT[c] = mem_req; trapT[c] = trap; haltT[c] = halted;
            selT[c] = pc_select; m2rT[c] = memToReg;
            tick();
        end
    endtask

    task automatic startInstr(input logic [6:0] op, input logic [2:0] f3);
        opcode = op; func3 = f3; go_contr = 1'b1;
        tick();
    endtask

    function automatic logic [6:0] legalOp(input int i);
        case (i)
            0: return O_LUI;   1: return O_AUIPC; 2: return O_JAL;
            3: return O_JALR;  4: return O_BR;    5: return O_LOAD;
            6: return O_STORE; 7: return O_IMM;   default: return O_OP;
        endcase
    endfunction

    task automatic pickInstr();
        int r;
        int v;
        r = $urandom_range(0, 31);
        if (r == 0) opcode = 7'($urandom);
        else if (r == 1) opcode = O_SYS;
        else opcode = legalOp(r % 9);
        func3 = 3'($urandom);
        if ($urandom_range(0, 7) != 0) begin
            if (opcode == O_LOAD) begin
                v = $urandom_range(0, 4);
                func3 = (v > 2) ? 3'(v + 1) : 3'(v);
            end else if (opcode == O_STORE) begin
                func3 = 3'($urandom_range(0, 2));
            end
        end
    endtask

    int cnt;

    initial begin
        #1;
        doReset();
        cmpOn = 1'b1;
        #1;
        check("reset_outputs",
              {irEn, pcEn, pc_select, aluSrc, regWrite, memToReg, isByte, isHalf, isWord,
               memRead, memWrite, mem_req, halted, trap, trap_cause}, 0);
        check("reset_retired", retired, 0);

        // ADDI, zero-wait memory: irEn in cycle 1, writeback in cycle 4.
        doReset();
        startInstr(O_IMM, 3'b000);
        trace(4);
        check("addi_irEn_c1", irT[1], 1);
        check("addi_rw_c3", rwT[3], 0);
        check("addi_wb_c4", {rwT[4], pcT[4], selT[4]}, 4'b1100);
        check("addi_retired", retired, 1);

        // BEQ taken then not taken, resolved in the EXEC cycle.
        doReset();
        comp = 1'b1;
        startInstr(O_BR, 3'b000);
        trace(3);
        check("beq_taken", {pcT[3], selT[3], rwT[3]}, 4'b1010);
        check("beq_retired1", retired, 1);
        comp = 1'b0;
        trace(3);
        check("beq_not_taken", {pcT[3], selT[3], rwT[3]}, 4'b1000);
        check("beq_retired2", retired, 2);

        // LW with three stall cycles in MEM.
        doReset();
        readySched = '{1, 1, 1, 0, 0, 0, 1, 1};
        startInstr(O_LOAD, 3'b010);
        trace(8);
        cnt = 0;
        for (int c = 4; c <= 8; c++) if (reqT[c] && rdT[c] && wT[c]) cnt++;
        check("lw_mem_cycles", cnt, 4);
        check("lw_wb", {rwT[8], m2rT[8]}, 3'b101);
        check("lw_retired", retired, 1);

        // Fetch timeout with mem_ready held low.
        doReset();
        for (int i = 0; i < 20; i++) readySched.push_back(1'b0);
        startInstr(O_IMM, 3'b000);
        trace(18);
        cnt = 0;
        for (int c = 1; c <= 18; c++) cnt += int'(reqT[c]) + 100 * int'(irT[c]);
        check("tmo_req_cycles", cnt, 17);
        check("tmo_trap_edge", {trapT[17], trapT[18]}, 2'b01);
        check("tmo_cause", trap_cause, 2'b10);
        check("tmo_retired", retired, 0);

        // Illegal opcode, illegal load size, ECALL.
        doReset();
        startInstr(7'b1111111, 3'b000);
        trace(3);
        check("ill_trap", {trapT[3], trap_cause, retired}, {1'b1, 2'b01, 32'd0});
        doReset();
        startInstr(O_LOAD, 3'b011);
        trace(3);
        check("size_trap", {trapT[3], trap_cause, retired}, {1'b1, 2'b11, 32'd0});
        doReset();
        startInstr(O_SYS, 3'b000);
        trace(3);
        check("ecall_halt", {haltT[3], trap, retired}, {1'b1, 1'b0, 32'd0});

        // Reset while a load waits in MEM.
        doReset();
        readySched = '{1, 1, 1, 0, 0};
        startInstr(O_LOAD, 3'b010);
        trace(5);
        #1;
        check("mid_mem_req", mem_req, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs",
              {irEn, pcEn, pc_select, aluSrc, regWrite, memToReg, isByte, isHalf, isWord,
               memRead, memWrite, mem_req, halted, trap, trap_cause, retired}, 0);
        reset = 1'b0;
        go_contr = 1'b0;
        tick();
        tick();
        #3;
        check("post_reset_idle", mem_req, 0);
        go_contr = 1'b1;
        tick();
        #3;
        check("post_reset_fetch", mem_req, 1);

        // Randomized instruction streams.
        for (int ep = 0; ep < 30; ep++) begin
            doReset();
            for (int c = 0; c < 150; c++) begin
                go_contr = ($urandom_range(0, 7) != 0);
                mem_ready = ($urandom_range(0, 3) != 0);
                comp = 1'($urandom);
                func7 = 7'($urandom);
                if (mIdle || (!mStop && mPlan[mPos] == "F")) pickInstr();
                tick();
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
